// File: rtl/fp_add_prealign.sv
// Binary32 add/sub front end: operand swap then mantissa alignment.
// Two-stage valid/ready pipeline with flush and synchronous reset.
module fp_add_prealign (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        operation_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        SA,
    output logic        SB,
    output logic        operation_code_o,
    output logic        flag_1_a,
    output logic        flag_1_b,
    output logic        flag_0_a,
    output logic        flag_0_b,
    output logic [7:0]  exp_big,
    output logic [26:0] mant_a,
    output logic [26:0] mant_b
);

    typedef struct packed {
        logic        sa;
        logic        sb;
        logic        op;
        logic        f1a;
        logic        f1b;
        logic        f0a;
        logic        f0b;
        logic [7:0]  exp_big;
        logic [7:0]  exp_small;
        logic [23:0] man_big;
        logic [23:0] man_small;
    } s1_t;

    logic        s1_valid;
    logic        s2_valid;
    s1_t         s1_q;
    s1_t         s1_d;
    logic        s1_load;
    logic        s2_load;

    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [7:0]  eff_a;
    logic [7:0]  eff_b;
    logic        swap;

    logic [7:0]  shift_d;
    logic [26:0] small_full;
    logic [26:0] small_shr;
    logic [26:0] lost_mask;
    logic [26:0] aligned;

    assign s2_load   = ~s2_valid | out_ready;
    assign s1_load   = ~s1_valid | s2_load;
    assign in_ready  = ~flush & s1_load;
    assign out_valid = s2_valid;

    assign exp_a = a[30:23];
    assign exp_b = b[30:23];
    assign eff_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
    assign eff_b = (exp_b == 8'd0) ? 8'd1 : exp_b;
    assign swap  = (eff_b > eff_a) |
                   ((eff_b == eff_a) & (b[22:0] > a[22:0]));

    always_comb begin
        s1_d    = '0;
        s1_d.op = operation_code;
        if (swap) begin
            s1_d.sa        = b[31] ^ operation_code;
            s1_d.sb        = a[31] ^ operation_code;
            s1_d.f1a       = &exp_b;
            s1_d.f1b       = &exp_a;
            s1_d.f0a       = ~|exp_b;
            s1_d.f0b       = ~|exp_a;
            s1_d.exp_big   = eff_b;
            s1_d.exp_small = eff_a;
            s1_d.man_big   = {|exp_b, b[22:0]};
            s1_d.man_small = {|exp_a, a[22:0]};
        end else begin
            s1_d.sa        = a[31];
            s1_d.sb        = b[31];
            s1_d.f1a       = &exp_a;
            s1_d.f1b       = &exp_b;
            s1_d.f0a       = ~|exp_a;
            s1_d.f0b       = ~|exp_b;
            s1_d.exp_big   = eff_a;
            s1_d.exp_small = eff_b;
            s1_d.man_big   = {|exp_a, a[22:0]};
            s1_d.man_small = {|exp_b, b[22:0]};
        end
    end

    // Shifts of 27 or more leave the mask all ones, so only sticky survives.
    assign shift_d    = s1_q.exp_big - s1_q.exp_small;
    assign small_full = {s1_q.man_small, 3'b000};
    assign small_shr  = small_full >> shift_d;
    assign lost_mask  = ~({27{1'b1}} << shift_d);
    assign aligned    = {small_shr[26:1],
                         small_shr[0] | (|(small_full & lost_mask))};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid         <= 1'b0;
            s1_q             <= '0;
            s2_valid         <= 1'b0;
            SA               <= 1'b0;
            SB               <= 1'b0;
            operation_code_o <= 1'b0;
            flag_1_a         <= 1'b0;
            flag_1_b         <= 1'b0;
            flag_0_a         <= 1'b0;
            flag_0_b         <= 1'b0;
            exp_big          <= 8'd0;
            mant_a           <= 27'd0;
            mant_b           <= 27'd0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    SA               <= s1_q.sa;
                    SB               <= s1_q.sb;
                    operation_code_o <= s1_q.op;
                    flag_1_a         <= s1_q.f1a;
                    flag_1_b         <= s1_q.f1b;
                    flag_0_a         <= s1_q.f0a;
                    flag_0_b         <= s1_q.f0b;
                    exp_big          <= s1_q.exp_big;
                    mant_a           <= {s1_q.man_big, 3'b000};
                    mant_b           <= aligned;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_add_prealign.sv
// Bench for fp_add_prealign: directed vectors, backpressure, flush,
// reset, then random traffic against a scoreboard of model results.
module tb_fp_add_prealign;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        operation_code;
    logic        out_valid;
    logic        out_ready;
    logic        SA;
    logic        SB;
    logic        operation_code_o;
    logic        flag_1_a;
    logic        flag_1_b;
    logic        flag_0_a;
    logic        flag_0_b;
    logic [7:0]  exp_big;
    logic [26:0] mant_a;
    logic [26:0] mant_b;

    int          total = 0;
    int          bad = 0;
    logic [68:0] q[$];
    logic        use_const;
    logic [68:0] const_exp;

    always #5 clk = ~clk;

    fp_add_prealign dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .operation_code(operation_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .SA(SA), .SB(SB), .operation_code_o(operation_code_o),
        .flag_1_a(flag_1_a), .flag_1_b(flag_1_b),
        .flag_0_a(flag_0_a), .flag_0_b(flag_0_b),
        .exp_big(exp_big), .mant_a(mant_a), .mant_b(mant_b)
    );

    function automatic logic [68:0] pack_dut();
        return {SA, SB, operation_code_o, flag_1_a, flag_1_b,
                flag_0_a, flag_0_b, exp_big, mant_a, mant_b};
    endfunction

    // Reference: magnitude ordering and alignment by plain integer arithmetic.
    function automatic logic [68:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic op);
        int     ex, ey, effx, effy, fx, fy;
        int     eb, es, effb, effs, fb, fs, d;
        longint mbig, msmall, mb, p;
        logic   sw, sa, sb;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = int'(x[22:0]);
        fy = int'(y[22:0]);
        effx = (ex == 0) ? 1 : ex;
        effy = (ey == 0) ? 1 : ey;
        sw = (effy > effx) || (effy == effx && fy > fx);
        if (sw) begin
            eb = ey; es = ex; fb = fy; fs = fx;
            effb = effy; effs = effx;
            sa = op ? ~y[31] : y[31];
            sb = op ? ~x[31] : x[31];
        end else begin
            eb = ex; es = ey; fb = fx; fs = fy;
            effb = effx; effs = effy;
            sa = x[31];
            sb = y[31];
        end
        mbig   = ((eb != 0) ? 64'd67108864 : 64'd0) + longint'(fb) * 8;
        msmall = ((es != 0) ? 64'd67108864 : 64'd0) + longint'(fs) * 8;
        d = effb - effs;
        if (d >= 27) begin
            mb = (msmall != 0) ? 1 : 0;
        end else begin
            p  = longint'(1) << d;
            mb = msmall / p;
            if ((msmall % p) != 0) mb = mb | 1;
        end
        return {sa, sb, op, eb == 255, es == 255, eb == 0, es == 0,
                8'(effb), 27'(mbig), 27'(mb)};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom % 8)
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[22:0]  = 23'd0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [68:0] obs,
                       input logic [68:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge with inputs already driven.
    task automatic tick();
        #1;
        if (!rst && !flush && out_valid) begin
            chk("out_nonempty", 69'(q.size() != 0), 69'd1);
            if (q.size() != 0) begin
                chk("out_data", pack_dut(), q[0]);
                if (out_ready) void'(q.pop_front());
            end
        end
        if (!rst && in_valid && in_ready)
            q.push_back(use_const ? const_exp : model(a, b, operation_code));
        if (rst || flush) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic op);
        in_valid = 1'b1;
        a = x;
        b = y;
        operation_code = op;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        operation_code = 1'b0;
        out_ready = 1'b1;
        use_const = 1'b0;
        const_exp = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 69'(out_valid), 69'd0);
        chk("rst_in_ready", 69'(in_ready), 69'd1);
        chk("rst_outputs", pack_dut(), 69'd0);

        use_const = 1'b1;
        const_exp = {3'b111, 4'b0000, 8'h80, 27'h6000000, 27'h2000000};
        send(32'h3F800000, 32'h40400000, 1'b1);
        in_valid = 1'b0;
        #1;
        chk("lat_cycle1", 69'(out_valid), 69'd0);
        tick();
        #1;
        chk("lat_cycle2", 69'(out_valid), 69'd1);
        tick();

        const_exp = {3'b000, 4'b0000, 8'h97, 27'h4000000, 27'h0000005};
        send(32'h4B800000, 32'h3F800001, 1'b0);
        const_exp = {3'b000, 4'b0000, 8'hC8, 27'h4000000, 27'h0000001};
        send(32'h64000000, 32'h3F800000, 1'b0);
        const_exp = {3'b000, 4'b1001, 8'hFF, 27'h4000000, 27'h0000000};
        send(32'h7F800000, 32'h00000000, 1'b0);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("directed_drain", 69'(q.size()), 69'd0);
        use_const = 1'b0;

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = rnd_fp();
            b = rnd_fp();
            operation_code = 1'($urandom);
            if (i == 2) begin
                #1;
                chk("bp_ready_third", 69'(in_ready), 69'd0);
            end
            tick();
        end
        chk("bp_accepted", 69'(q.size()), 69'd2);
        out_ready = 1'b1;
        send(rnd_fp(), rnd_fp(), 1'b1);
        send(rnd_fp(), rnd_fp(), 1'b0);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_drain", 69'(q.size()), 69'd0);

        send(rnd_fp(), rnd_fp(), 1'b0);
        send(rnd_fp(), rnd_fp(), 1'b1);
        flush = 1'b1;
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h3F800000;
        #1;
        chk("flush_in_ready", 69'(in_ready), 69'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 69'(out_valid), 69'd0);
        chk("flush_in_ready_after", 69'(in_ready), 69'd1);
        repeat (3) tick();

        send(rnd_fp(), rnd_fp(), 1'b0);
        send(rnd_fp(), rnd_fp(), 1'b1);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", 69'(out_valid), 69'd0);
        chk("mid_rst_in_ready", 69'(in_ready), 69'd1);
        chk("mid_rst_outputs", pack_dut(), 69'd0);
        repeat (3) tick();

        for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 60) == 0;
            a = rnd_fp();
            b = rnd_fp();
            case ($urandom % 4)
                0: b[30:23] = a[30:23] - 8'($urandom % 30);
                1: b = a ^ 32'h80000000;
                default: ;
            endcase
            operation_code = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
        repeat (4) tick();
        chk("final_drain", 69'(q.size()), 69'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_add_prealign.md
FP_ADD_PREALIGN -- requirements
Module: fp_add_prealign

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk rises, rst is sampled only on clk rising edge.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  synchronous pipeline clear.
REQ-005 in_valid  input  1  operand pair present; in_ready  output  1  stage can accept.
REQ-006 a, b  input  32 each  IEEE-754 binary32 operands; operation_code  input  1  0 add, 1 subtract.
REQ-007 out_valid  output  1  aligned result present; out_ready  input  1  downstream Control_Unit/adder stage accepts.
REQ-008 SA, SB  output  1 each  signs after swap and subtract correction.
REQ-009 operation_code_o  output  1  operation_code passed through unchanged.
REQ-010 flag_1_a, flag_1_b  output  1 each  swapped operand exponent == 0xFF (inf/NaN).
REQ-011 flag_0_a, flag_0_b  output  1 each  swapped operand exponent == 0x00 (zero/denormal).
REQ-012 exp_big  output  8  effective exponent of larger-magnitude operand.
REQ-013 mant_a, mant_b  output  27 each  {hidden, fraction[22:0], guard, round, sticky}; mant_b aligned.

Function
REQ-014 Two register stages (S1 swap, S2 align), each with its own valid bit; latency SHALL be 2 cycles from accept to out_valid with out_ready held 1.
REQ-015 Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready; throughput one pair per cycle when unstalled.
REQ-016 S2 loads when S2 empty or S2 transferring out; S1 loads when S1 empty or S1 moving to S2.
REQ-017 in_ready = ~flush & (~S1_valid | S1 moving to S2), combinational from state and out_ready only (not from in_valid).
REQ-018 While out_valid=1 and out_ready=0, all S2 outputs SHALL hold stable.
REQ-019 Hidden bit = ~(exponent==0); effective exponent = 1 when exponent==0, else exponent.
REQ-020 S1 swap = (eff_exp_b > eff_exp_a) | (eff_exp equal & frac_b > frac_a); ties do not swap.
REQ-021 Signs: no swap -> SA=sign_a, SB=sign_b; swap & add -> SA=sign_b, SB=sign_a; swap & subtract -> SA=~sign_b, SB=~sign_a.
REQ-022 flag_1_x / flag_0_x follow their operand through the swap.
REQ-023 S2: d = exp_big - exp_small (unsigned 8-bit, never negative after swap); mant_b = ({hidden,frac,3'b000} >> d) with bit0 ORed with every bit shifted out.
REQ-024 d >= 27: mant_b = 27'd1 if small mantissa nonzero, else 0.
REQ-025 mant_a = {hidden, frac, 3'b000} of larger operand, never shifted.
REQ-026 Inf/NaN and zero operands SHALL pass through the same datapath unmodified; exception handling is downstream.
REQ-027 flush=1 clears both valid bits next edge; no input accepted that cycle; flush & in_valid same cycle -> input dropped.
REQ-028 rst has priority over flush and all transfers.

Reset
REQ-029 On rst: S1_valid=0, S2_valid=0, out_valid=0, in_ready=1 next cycle; SA, SB, operation_code_o, all flags, exp_big, mant_a, mant_b = 0.
REQ-030 rst asserted mid-operation discards all in-flight pairs; no out_valid until a new pair is accepted after rst deasserts.

Verification
REQ-031 a=0x3F800000, b=0x40400000, op=1, out_ready=1 accepted cycle 0 -> cycle 2: out_valid=1, SA=1, SB=1, exp_big=0x80, mant_a=0x6000000, mant_b=0x2000000.
REQ-032 a=0x4B800000, b=0x3F800001, op=0 -> exp_big=0x97, mant_a=0x4000000, mant_b=0x0000005 (sticky set), SA=SB=0.
REQ-033 a=0x64000000, b=0x3F800000 (d=73) -> mant_b=0x0000001; a=0x7F800000, b=0 -> flag_1_a=1, flag_0_b=1, mant_b=0.
REQ-034 out_ready=0, four back-to-back in_valid -> exactly 2 accepted, in_ready=0 from third, outputs stable; out_ready=1 -> both drained in order, then remaining accepted.
REQ-035 Two pairs in flight, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped pair never appears; same with rst -> all outputs 0.
